// File: rtl/sdram_controller.sv
// Command sequencer for the four-bank sdram_block: single-word read/write requests,
// open-row tracking per bank and periodic refresh.
module sdram_controller #(
   parameter int unsigned ROW_BITS         = 13,
   parameter int unsigned COL_BITS         = 10,
   parameter int unsigned T_RCD            = 2,
   parameter int unsigned T_RP             = 2,
   parameter int unsigned T_RFC            = 7,
   parameter int unsigned CAS_LATENCY      = 2,
   parameter int unsigned REFRESH_INTERVAL = 780,
   parameter int unsigned INIT_CYCLES      = 100
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [2+ROW_BITS+COL_BITS-1:0]   req_address,
   input  logic [31:0]                      req_wdata,
   output logic                             resp_valid,
   output logic [31:0]                      resp_rdata,
   output logic                             sd_clock_enable,
   output logic [2:0]                       sd_command,
   output logic [1:0]                       sd_bank_address,
   output logic [12:0]                      sd_address,
   output logic                             sd_wr_en,
   output logic [31:0]                      sd_wdata,
   output logic                             sd_data_oe,
   input  logic [31:0]                      sd_rdata
);

   localparam int unsigned AddrBits = 2 + ROW_BITS + COL_BITS;

   localparam logic [2:0] CmdNop       = 3'd0;
   localparam logic [2:0] CmdActivate  = 3'd1;
   localparam logic [2:0] CmdRead      = 3'd2;
   localparam logic [2:0] CmdWrite     = 3'd3;
   localparam logic [2:0] CmdPrecharge = 3'd4;
   localparam logic [2:0] CmdRefresh   = 3'd5;
   localparam logic [12:0] AllBanks    = 13'h400;

   typedef enum logic [3:0] {
      StInitWait, StInitPrecharge, StInitRp, StInitRefresh, StInitRfc,
      StIdle, StActivate, StRcdWait, StAccess, StCasWait,
      StPrecharge, StRpWait, StRefPrecharge, StRefRp, StRefresh, StRfcWait
   } state_e;

   state_e               state_q, state_d;
   logic [15:0]          wait_q, wait_d;
   logic [15:0]          refresh_cnt_q;
   logic                 refresh_pending_q;
   logic                 refresh_issue;
   logic [3:0]           open_q, open_d;
   logic [ROW_BITS-1:0]  open_row_q [4];
   logic [ROW_BITS-1:0]  open_row_d [4];
   logic                 write_q;
   logic [1:0]           bank_q;
   logic [ROW_BITS-1:0]  row_q;
   logic [COL_BITS-1:0]  col_q;
   logic [31:0]          wdata_q;
   logic                 resp_valid_q;
   logic [31:0]          resp_rdata_q;
   logic                 accept;
   logic                 cas_done;
   logic [1:0]           req_bank;
   logic [ROW_BITS-1:0]  req_row;
   logic [COL_BITS-1:0]  req_col;

   assign req_bank        = req_address[AddrBits-1 -: 2];
   assign req_row         = req_address[COL_BITS +: ROW_BITS];
   assign req_col         = req_address[COL_BITS-1:0];
   assign req_ready       = (state_q == StIdle) && !refresh_pending_q;
   assign accept          = req_valid && req_ready;
   assign cas_done        = (state_q == StCasWait) && (wait_q == 16'(CAS_LATENCY - 1));
   assign refresh_issue   = (state_q == StRefresh) || (state_q == StInitRefresh);
   assign sd_clock_enable = 1'b1;
   assign resp_valid      = resp_valid_q;
   assign resp_rdata      = resp_rdata_q;

   // Wait states hold for T-1 cycles so the next command lands exactly T cycles later.
   always_comb begin
      state_d         = state_q;
      wait_d          = '0;
      open_d          = open_q;
      open_row_d      = open_row_q;
      sd_command      = CmdNop;
      sd_bank_address = 2'd0;
      sd_address      = 13'd0;
      sd_wr_en        = 1'b0;
      sd_wdata        = 32'd0;
      sd_data_oe      = 1'b0;
      unique case (state_q)
         StInitWait: begin
            if (wait_q == 16'(INIT_CYCLES - 1)) state_d = StInitPrecharge;
            else wait_d = wait_q + 16'd1;
         end
         StInitPrecharge, StRefPrecharge: begin
            sd_command = CmdPrecharge;
            sd_address = AllBanks;
            open_d     = '0;
            state_d    = (state_q == StInitPrecharge) ? StInitRp : StRefRp;
         end
         StInitRp, StRefRp: begin
            if (wait_q == 16'(T_RP - 2)) begin
               state_d = (state_q == StInitRp) ? StInitRefresh : StRefresh;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         StInitRefresh, StRefresh: begin
            sd_command = CmdRefresh;
            open_d     = '0;
            state_d    = (state_q == StInitRefresh) ? StInitRfc : StRfcWait;
         end
         StInitRfc, StRfcWait: begin
            if (wait_q == 16'(T_RFC - 2)) state_d = StIdle;
            else wait_d = wait_q + 16'd1;
         end
         StIdle: begin
            if (refresh_pending_q) begin
               state_d = (|open_q) ? StRefPrecharge : StRefresh;
            end else if (req_valid) begin
               if (open_q[req_bank] && open_row_q[req_bank] == req_row) state_d = StAccess;
               else if (open_q[req_bank]) state_d = StPrecharge;
               else state_d = StActivate;
            end
         end
         StPrecharge: begin
            sd_command      = CmdPrecharge;
            sd_bank_address = bank_q;
            open_d[bank_q]  = 1'b0;
            state_d         = StRpWait;
         end
         StRpWait: begin
            if (wait_q == 16'(T_RP - 2)) state_d = StActivate;
            else wait_d = wait_q + 16'd1;
         end
         StActivate: begin
            sd_command         = CmdActivate;
            sd_bank_address    = bank_q;
            sd_address         = 13'(row_q);
            open_d[bank_q]     = 1'b1;
            open_row_d[bank_q] = row_q;
            state_d            = StRcdWait;
         end
         StRcdWait: begin
            if (wait_q == 16'(T_RCD - 2)) state_d = StAccess;
            else wait_d = wait_q + 16'd1;
         end
         StAccess: begin
            sd_bank_address = bank_q;
            sd_address      = 13'(col_q);
            if (write_q) begin
               sd_command = CmdWrite;
               sd_wr_en   = 1'b1;
               sd_data_oe = 1'b1;
               sd_wdata   = wdata_q;
               state_d    = StIdle;
            end else begin
               sd_command = CmdRead;
               state_d    = StCasWait;
            end
         end
         StCasWait: begin
            if (cas_done) state_d = StIdle;
            else wait_d = wait_q + 16'd1;
         end
         default: state_d = StInitWait;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q           <= StInitWait;
         wait_q            <= '0;
         open_q            <= '0;
         for (int i = 0; i < 4; i++) open_row_q[i] <= '0;
         write_q           <= 1'b0;
         bank_q            <= '0;
         row_q             <= '0;
         col_q             <= '0;
         wdata_q           <= '0;
         resp_valid_q      <= 1'b0;
         resp_rdata_q      <= '0;
         refresh_cnt_q     <= 16'(REFRESH_INTERVAL - 1);
         refresh_pending_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         open_q     <= open_d;
         open_row_q <= open_row_d;
         if (accept) begin
            write_q <= req_write;
            bank_q  <= req_bank;
            row_q   <= req_row;
            col_q   <= req_col;
            wdata_q <= req_wdata;
         end
         resp_valid_q <= cas_done;
         if (cas_done) resp_rdata_q <= sd_rdata;
         // Expiry wins over a same-cycle REFRESH so no interval is lost.
         if (refresh_cnt_q == '0) begin
            refresh_cnt_q     <= 16'(REFRESH_INTERVAL - 1);
            refresh_pending_q <= 1'b1;
         end else begin
            refresh_cnt_q <= refresh_cnt_q - 16'd1;
            if (refresh_issue) refresh_pending_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sdram_controller.sv
// Self-checking bench for sdram_controller: cycle-exact command checks plus a read-data
// scoreboard fed from a behavioural SDRAM model.
module tb_sdram_controller;

   localparam logic [2:0] CmdNop = 3'd0, CmdAct = 3'd1, CmdRd = 3'd2, CmdWr = 3'd3;
   localparam logic [2:0] CmdPre = 3'd4, CmdRef = 3'd5;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [24:0] req_address = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        sd_clock_enable;
   logic [2:0]  sd_command;
   logic [1:0]  sd_bank_address;
   logic [12:0] sd_address;
   logic        sd_wr_en;
   logic [31:0] sd_wdata;
   logic        sd_data_oe;
   logic [31:0] sd_rdata;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [31:0] ref_mem [logic [24:0]];
   logic [31:0] model_mem [logic [24:0]];
   logic [12:0] model_row [4];
   logic [31:0] exp_q [$];
   logic [31:0] rd_p0 = 32'hBADD_F00D;
   logic [31:0] rd_p1 = 32'hBADD_F00D;

   sdram_controller dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_address     (req_address),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .sd_clock_enable (sd_clock_enable),
      .sd_command      (sd_command),
      .sd_bank_address (sd_bank_address),
      .sd_address      (sd_address),
      .sd_wr_en        (sd_wr_en),
      .sd_wdata        (sd_wdata),
      .sd_data_oe      (sd_data_oe),
      .sd_rdata        (sd_rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else cyc <= cyc + 1;
   end

   function automatic logic [24:0] mk(input logic [1:0] b, input logic [12:0] r,
                                      input logic [9:0] c);
      return {b, r, c};
   endfunction

   function automatic logic [31:0] fill(input logic [24:0] a);
      return {7'h55, a} ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] ref_read(input logic [24:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fill(a);
   endfunction

   // Behavioural SDRAM: tracks activated rows, stores writes, returns reads after CL=2.
   always @(posedge clock) begin
      logic [24:0] a;
      a = {sd_bank_address, model_row[sd_bank_address], sd_address[9:0]};
      if (sd_command == CmdAct) model_row[sd_bank_address] <= sd_address;
      if (sd_command == CmdWr && sd_wr_en && sd_data_oe) model_mem[a] = sd_wdata;
      rd_p1 <= rd_p0;
      if (sd_command == CmdRd) rd_p0 <= model_mem.exists(a) ? model_mem[a] : fill(a);
      else rd_p0 <= 32'hBADD_F00D;
   end
   assign sd_rdata = rd_p1;

   task automatic send(input logic wr, input logic [24:0] a, input logic [31:0] d);
      req_valid   = 1'b1;
      req_write   = wr;
      req_address = a;
      req_wdata   = d;
      @(negedge clock);
      req_valid   = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      tests++;
      if (sd_command !== CmdNop || req_ready !== 1'b0 || resp_valid !== 1'b0 ||
          sd_wr_en !== 1'b0 || sd_data_oe !== 1'b0 || sd_clock_enable !== 1'b1 ||
          resp_rdata !== 32'd0 || sd_wdata !== 32'd0 || sd_address !== 13'd0 ||
          sd_bank_address !== 2'd0) begin
         fails++;
         $display("FAIL reset_values: cmd=%0d ready=%b rv=%b we=%b oe=%b cke=%b addr=%h (want all idle)",
                  sd_command, req_ready, resp_valid, sd_wr_en, sd_data_oe, sd_clock_enable,
                  sd_address);
      end
      reset_n = 1'b1;
      for (int c = 0; c <= 109; c++) begin
         logic [2:0] ec;
         ec = (c == 100) ? CmdPre : (c == 102) ? CmdRef : CmdNop;
         tests++;
         if (sd_command !== ec || req_ready !== (c == 109)) begin
            fails++;
            $display("FAIL init_seq c=%0d: cmd=%0d ready=%b, want cmd=%0d ready=%b",
                     c, sd_command, req_ready, ec, (c == 109));
         end
         if (c == 100) begin
            tests++;
            if (sd_address[10] !== 1'b1) begin
               fails++;
               $display("FAIL init_pre_all: a10=%b want 1", sd_address[10]);
            end
         end
         if (c < 109) @(negedge clock);
      end
   endtask

   task automatic test_write_closed();
      logic [24:0] a;
      a = mk(2'd1, 13'd5, 10'd3);
      ref_mem[a] = 32'hDEAD_BEEF;
      send(1'b1, a, 32'hDEAD_BEEF);
      tests++;
      if (sd_command !== CmdAct || sd_bank_address !== 2'd1 || sd_address !== 13'd5) begin
         fails++;
         $display("FAIL wr_activate: cmd=%0d bank=%0d addr=%0d want 1/1/5",
                  sd_command, sd_bank_address, sd_address);
      end
      repeat (2) @(negedge clock);
      tests++;
      if (sd_command !== CmdWr || sd_address !== 13'd3 || sd_bank_address !== 2'd1 ||
          sd_data_oe !== 1'b1 || sd_wr_en !== 1'b1 || sd_wdata !== 32'hDEAD_BEEF) begin
         fails++;
         $display("FAIL wr_cmd: cmd=%0d addr=%0d oe=%b we=%b data=%h want 3/3/1/1/deadbeef",
                  sd_command, sd_address, sd_data_oe, sd_wr_en, sd_wdata);
      end
      @(negedge clock);
      tests++;
      if (req_ready !== 1'b1 || sd_command !== CmdNop || sd_data_oe !== 1'b0) begin
         fails++;
         $display("FAIL wr_ready: ready=%b cmd=%0d oe=%b want 1/0/0",
                  req_ready, sd_command, sd_data_oe);
      end
   endtask

   task automatic test_read_hit();
      logic [24:0] a;
      a = mk(2'd1, 13'd5, 10'd3);
      exp_q.push_back(ref_read(a));
      send(1'b0, a, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         logic [2:0] ec;
         ec = (k == 1) ? CmdRd : CmdNop;
         tests++;
         if (sd_command !== ec || resp_valid !== (k == 4)) begin
            fails++;
            $display("FAIL hit_timing k=%0d: cmd=%0d rv=%b want %0d/%b",
                     k, sd_command, resp_valid, ec, (k == 4));
         end
         if (k == 1 && sd_address !== 13'd3) begin
            fails++;
            $display("FAIL hit_col: addr=%0d want 3", sd_address);
         end
         if (k == 4) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL hit_data: response with empty scoreboard");
            end else if (resp_rdata !== exp_q[0] || req_ready !== 1'b1) begin
               fails++;
               $display("FAIL hit_data: data=%h ready=%b want %h/1",
                        resp_rdata, req_ready, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               void'(exp_q.pop_front());
            end
         end
         if (k < 5) @(negedge clock);
      end
   endtask

   task automatic test_read_miss();
      logic [24:0] a;
      a = mk(2'd1, 13'd6, 10'd3);
      exp_q.push_back(ref_read(a));
      send(1'b0, a, 32'd0);
      for (int k = 1; k <= 8; k++) begin
         logic [2:0] ec;
         ec = (k == 1) ? CmdPre : (k == 3) ? CmdAct : (k == 5) ? CmdRd : CmdNop;
         tests++;
         if (sd_command !== ec || resp_valid !== (k == 8)) begin
            fails++;
            $display("FAIL miss_timing k=%0d: cmd=%0d rv=%b want %0d/%b",
                     k, sd_command, resp_valid, ec, (k == 8));
         end
         if ((k == 1 && (sd_address[10] !== 1'b0 || sd_bank_address !== 2'd1)) ||
             (k == 3 && sd_address !== 13'd6)) begin
            fails++;
            $display("FAIL miss_fields k=%0d: bank=%0d addr=%h", k, sd_bank_address, sd_address);
         end
         if (k == 8) begin
            tests++;
            if (exp_q.size() == 0 || resp_rdata !== exp_q[0]) begin
               fails++;
               $display("FAIL miss_data: data=%h want %h", resp_rdata,
                        (exp_q.size() != 0) ? exp_q[0] : 32'hx);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         if (k < 8) @(negedge clock);
      end
   endtask

   task automatic test_refresh();
      logic [24:0] a;
      a = mk(2'd1, 13'd6, 10'd3);
      while (cyc < 777) @(negedge clock);
      tests++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL ref_pre_ready: ready=%b want 1", req_ready);
      end
      exp_q.push_back(ref_read(a));
      send(1'b0, a, 32'd0);
      for (int k = 1; k <= 14; k++) begin
         logic [2:0] ec;
         ec = (k == 1) ? CmdRd : (k == 5) ? CmdPre : (k == 7) ? CmdRef : CmdNop;
         tests++;
         if (sd_command !== ec || resp_valid !== (k == 4) || req_ready !== (k == 14)) begin
            fails++;
            $display("FAIL ref_seq k=%0d: cmd=%0d rv=%b ready=%b want %0d/%b/%b",
                     k, sd_command, resp_valid, req_ready, ec, (k == 4), (k == 14));
         end
         if (k == 5 && sd_address[10] !== 1'b1) begin
            fails++;
            $display("FAIL ref_pre_all: a10=%b want 1", sd_address[10]);
         end
         if (k == 4) begin
            tests++;
            if (exp_q.size() == 0 || resp_rdata !== exp_q[0]) begin
               fails++;
               $display("FAIL ref_read_data: data=%h want %h", resp_rdata,
                        (exp_q.size() != 0) ? exp_q[0] : 32'hx);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         if (k < 14) @(negedge clock);
      end
      exp_q.push_back(ref_read(a));
      send(1'b0, a, 32'd0);
      for (int k = 1; k <= 6; k++) begin
         logic [2:0] ec;
         ec = (k == 1) ? CmdAct : (k == 3) ? CmdRd : CmdNop;
         tests++;
         if (sd_command !== ec || resp_valid !== (k == 6)) begin
            fails++;
            $display("FAIL post_ref k=%0d: cmd=%0d rv=%b want %0d/%b",
                     k, sd_command, resp_valid, ec, (k == 6));
         end
         if (k == 6) begin
            tests++;
            if (exp_q.size() == 0 || resp_rdata !== exp_q[0]) begin
               fails++;
               $display("FAIL post_ref_data: data=%h want %h", resp_rdata,
                        (exp_q.size() != 0) ? exp_q[0] : 32'hx);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         if (k < 6) @(negedge clock);
      end
   endtask

   task automatic test_reset_mid();
      logic [24:0] a;
      a = mk(2'd2, 13'd7, 10'd9);
      @(negedge clock);
      send(1'b1, a, 32'hCAFE_F00D);
      tests++;
      if (sd_command !== CmdAct) begin
         fails++;
         $display("FAIL mid_activate: cmd=%0d want 1", sd_command);
      end
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      tests++;
      if (sd_command !== CmdNop || req_ready !== 1'b0 || sd_wr_en !== 1'b0 ||
          sd_data_oe !== 1'b0 || sd_address !== 13'd0 || sd_bank_address !== 2'd0 ||
          sd_wdata !== 32'd0 || resp_valid !== 1'b0 || sd_clock_enable !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset_values: cmd=%0d ready=%b oe=%b addr=%h bank=%0d",
                  sd_command, req_ready, sd_data_oe, sd_address, sd_bank_address);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c <= 109; c++) begin
         logic [2:0] ec;
         ec = (c == 100) ? CmdPre : (c == 102) ? CmdRef : CmdNop;
         tests++;
         if (sd_command !== ec || req_ready !== (c == 109)) begin
            fails++;
            $display("FAIL reinit_seq c=%0d: cmd=%0d ready=%b want %0d/%b",
                     c, sd_command, req_ready, ec, (c == 109));
         end
         if (c < 109) @(negedge clock);
      end
      // The aborted write must never have reached the array.
      exp_q.push_back(ref_read(a));
      send(1'b0, a, 32'd0);
      for (int k = 1; k <= 6; k++) begin
         logic [2:0] ec;
         ec = (k == 1) ? CmdAct : (k == 3) ? CmdRd : CmdNop;
         tests++;
         if (sd_command !== ec || resp_valid !== (k == 6)) begin
            fails++;
            $display("FAIL post_reset k=%0d: cmd=%0d rv=%b want %0d/%b",
                     k, sd_command, resp_valid, ec, (k == 6));
         end
         if (k == 6) begin
            tests++;
            if (exp_q.size() == 0 || resp_rdata !== exp_q[0]) begin
               fails++;
               $display("FAIL post_reset_data: data=%h want %h", resp_rdata,
                        (exp_q.size() != 0) ? exp_q[0] : 32'hx);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         if (k < 6) @(negedge clock);
      end
   endtask

   initial begin
      test_reset();
      test_write_closed();
      test_read_hit();
      test_read_miss();
      test_refresh();
      test_reset_mid();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sdram_controller.md
# sdram_controller

Command sequencer for the four-bank `sdram_block`. It accepts single-word read/write requests from the memory-side requester over a valid/ready handshake and splits each word address into bank, row and column. It issues ACTIVATE/READ/WRITE/PRECHARGE/REFRESH commands with the required inter-command delays, keeps one open row per bank, and schedules periodic refresh. It sits between the CPU memory interface and `sdram_block`, and drives the block's bidirectional data bus through separate out/enable signals.

## Interface
- `ROW_BITS`, 13: row address width.
- `COL_BITS`, 10: column address width (must be ≤ 10).
- `T_RCD`, 2: cycles from ACTIVATE to READ/WRITE.
- `T_RP`, 2: cycles from PRECHARGE to ACTIVATE/REFRESH.
- `T_RFC`, 7: cycles from REFRESH to next command.
- `CAS_LATENCY`, 2: cycles from READ command to valid `sd_rdata`.
- `REFRESH_INTERVAL`, 780: cycles between refresh requests.
- `INIT_CYCLES`, 100: NOP cycles after reset before initialisation commands.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller accepts request this cycle.
- `req_write`  in  1  1 = write, 0 = read.
- `req_address`  in  2+ROW_BITS+COL_BITS  word address; fields {bank[1:0], row, col} from MSB.
- `req_wdata`  in  32  write data.
- `resp_valid`  out  1  one-cycle read-data strobe.
- `resp_rdata`  out  32  read data.
- `sd_clock_enable`  out  1  to `clock_enable`.
- `sd_command`  out  3  0 NOP, 1 ACTIVATE, 2 READ, 3 WRITE, 4 PRECHARGE, 5 REFRESH.
- `sd_bank_address`  out  2  target bank.
- `sd_address`  out  13  row (ACTIVATE); column in [COL_BITS-1:0] (READ/WRITE); bit 10 = all-banks flag (PRECHARGE).
- `sd_wr_en`  out  1  high only with a WRITE command.
- `sd_wdata`  out  32  data driven to `rw_data`.
- `sd_data_oe`  out  1  tri-state enable for `rw_data`; high only in the WRITE command cycle.
- `sd_rdata`  in  32  `rw_data` as seen by the controller.

## Operation
- States:
  - Init path: INIT_WAIT → INIT_PRECHARGE → INIT_RP → INIT_REFRESH → INIT_RFC.
  - Normal path: IDLE → ACTIVATE → RCD_WAIT → ACCESS → CAS_WAIT → IDLE.
  - Row miss: PRECHARGE → RP_WAIT → ACTIVATE.
  - Refresh: REF_PRECHARGE → REF_RP → REFRESH → RFC_WAIT → IDLE.
- Open-row table: per bank, an `open` flag and a ROW_BITS row register. Reset, any REFRESH and any all-bank PRECHARGE clear all `open` flags.
- `req_ready` is high only in IDLE with initialisation complete and no refresh pending. A request is accepted when `req_valid && req_ready`; address and data are captured into registers on that edge.
- Bank state on acceptance:
  - Row hit (`open`, row equal): go straight to ACCESS.
  - Bank closed: go to ACTIVATE.
  - Different row open: single-bank PRECHARGE (`sd_address[10]`=0), then ACTIVATE.
- ACCESS issues READ or WRITE with `sd_address[10]`=0, so auto-precharge is never used. The row is left open afterwards.
- Write: WRITE, `sd_wr_en`, `sd_data_oe` and `sd_wdata` are all valid in the same single cycle. The controller then returns to IDLE.
- Read: `sd_rdata` is sampled CAS_LATENCY cycles after the READ cycle. `resp_rdata`/`resp_valid` are registered and appear one cycle later. At most one read is outstanding.
- Refresh counter:
  - Counts down from REFRESH_INTERVAL-1 and reloads on reaching 0, setting `refresh_pending`.
  - A request in flight completes first. From IDLE with the flag set, the controller issues an all-bank PRECHARGE if any bank is open (otherwise it skips to REFRESH).
  - Issuing REFRESH clears the flag.
  - An expiry that coincides with REFRESH issue sets the flag again; it is not lost.
- `sd_clock_enable` is held at 1 in all states.

## Timing
- Values during reset: `sd_command`=NOP; `req_ready`, `resp_valid`, `sd_wr_en` and `sd_data_oe` = 0; `resp_rdata`, `sd_wdata`, `sd_address` and `sd_bank_address` = 0; `sd_clock_enable`=1.
- Reset asserted mid-operation: the controller returns immediately to INIT_WAIT, the open table is cleared, any pending response is dropped, and the refresh counter is reloaded.
- Numbering: the acceptance edge ends cycle N.
  - Hit: command in cycle N+1.
  - Closed bank: ACTIVATE at N+1, command at N+1+T_RCD.
  - Miss: PRECHARGE at N+1, ACTIVATE at N+1+T_RP, command at N+1+T_RP+T_RCD.
- Write: `req_ready` returns in the cycle after WRITE.
- Read: for READ in cycle C, `resp_valid` is high in C+CAS_LATENCY+1, and `req_ready` is high in that same cycle.
- Initialisation, counting from reset release (cycle 0):
  - NOP for INIT_CYCLES.
  - All-bank PRECHARGE at cycle INIT_CYCLES.
  - REFRESH at INIT_CYCLES+T_RP.
  - `req_ready` first high at INIT_CYCLES+T_RP+T_RFC.
- Every wait state issues NOP.
- No two non-NOP commands are ever issued back-to-back unless the hit path allows it.

## Test plan
- Reset release with defaults → NOP through cycle 99, PRECHARGE with `sd_address[10]`=1 at cycle 100, REFRESH at 102, `req_ready`=1 at 109.
- Write 0xDEADBEEF to bank 1, row 5, col 3 (closed bank), accepted at N → ACTIVATE bank 1 with address 5 at N+1; WRITE with address 3, `sd_data_oe`=1 and data 0xDEADBEEF at N+3; `req_ready` at N+4.
- Read of the same address accepted at M (row hit) → READ at M+1; the model drives 0xDEADBEEF at M+3; `resp_valid`=1 with 0xDEADBEEF at M+4 only.
- Read of bank 1, row 6 (row miss) accepted at M → PRECHARGE bank 1 with `sd_address[10]`=0 at M+1, ACTIVATE row 6 at M+3, READ at M+5, `resp_valid` at M+8.
- Refresh expiry during a read in flight → the read completes, `req_ready` stays 0, then all-bank PRECHARGE, REFRESH T_RP later, and `req_ready` returns T_RFC later. The next access to bank 1 issues ACTIVATE (the row is closed).
- Assert `reset_n` between ACTIVATE and WRITE → all outputs return to their reset values immediately, no WRITE is issued, and the full init sequence repeats.
